// File: rtl/host_fifo_arb.sv
// Shares one host TX/RX byte-FIFO pair between two host-bus clients.
// TX packets are serialised round-robin; RX packets are routed by header bit 7.
module host_fifo_arb #(
    parameter int DROP_W = 8
) (
    input  logic              CLK,
    input  logic              RESETn,
    input  logic              C0_WREN,
    input  logic [7:0]        C0_WRDATA,
    output logic              C0_WRFULL,
    input  logic              C0_RDEN,
    output logic              C0_RDEMPTY,
    output logic [7:0]        C0_RDDATA,
    input  logic              C1_WREN,
    input  logic [7:0]        C1_WRDATA,
    output logic              C1_WRFULL,
    input  logic              C1_RDEN,
    output logic              C1_RDEMPTY,
    output logic [7:0]        C1_RDDATA,
    output logic              H_WREN,
    output logic [7:0]        H_WRDATA,
    input  logic              H_WRFULL,
    output logic              H_RDEN,
    input  logic              H_RDEMPTY,
    input  logic [7:0]        H_RDDATA,
    output logic              ERR,
    output logic [DROP_W-1:0] DROP_CNT
);

    function automatic logic [3:0] pkt_len(input logic [2:0] code);
        return (code == 3'd7) ? 4'd8 : {1'b0, code};
    endfunction

    typedef enum logic [1:0] {OFFER, SAMPLE, PKT} tx_t;
    typedef enum logic {HDR, PAY} rx_t;

    tx_t         tx_q, tx_d;
    logic        turn_q, turn_d;
    logic        grant_q, grant_d;
    logic [3:0]  rem_q, rem_d, rem_nxt;
    logic [1:0]  offer, offer_q, wren, acc, drop;
    logic [3:0]  hdr_len;
    logic [DROP_W:0] drop_sum;

    rx_t         rx_q, rx_d;
    logic        pop_q, hb_valid, hb_dst, dst_q, rd0, rd1;
    logic [7:0]  hb;
    logic [3:0]  rrem_q;

    assign wren     = {C1_WREN, C0_WREN};
    assign acc      = wren & offer_q;
    assign drop     = wren & ~offer_q;
    assign H_WREN   = |acc;
    assign H_WRDATA = acc[1] ? C1_WRDATA : C0_WRDATA;
    assign hdr_len  = pkt_len(H_WRDATA[6:4]);
    assign rem_nxt  = rem_q - {3'd0, H_WREN};
    assign drop_sum = {1'b0, DROP_CNT} + {{DROP_W{1'b0}}, drop[0]}
                    + {{DROP_W{1'b0}}, drop[1]};

    always_ff @(posedge CLK) begin
        if (!RESETn) tx_q <= OFFER;
        else         tx_q <= tx_d;
    end

    always_comb begin
        tx_d    = tx_q;
        turn_d  = turn_q;
        grant_d = grant_q;
        rem_d   = rem_q;
        unique case (tx_q)
            OFFER: if (!H_WRFULL) tx_d = SAMPLE;
            SAMPLE: begin
                turn_d = ~turn_q;
                tx_d   = OFFER;
                if (H_WREN && hdr_len != 4'd0) begin
                    turn_d  = turn_q;
                    grant_d = turn_q;
                    rem_d   = hdr_len;
                    tx_d    = PKT;
                end
            end
            PKT: begin
                rem_d = rem_nxt;
                if (rem_nxt == 4'd0) begin
                    turn_d = ~grant_q;
                    tx_d   = OFFER;
                end
            end
            default: tx_d = OFFER;
        endcase
    end

    // An offer is one byte slot; during a packet it is renewed combinationally
    always_comb begin
        offer = 2'b00;
        if (RESETn) begin
            unique case (tx_q)
                OFFER:   offer[turn_q]  = !H_WRFULL;
                PKT:     offer[grant_q] = (rem_nxt != 4'd0) && !H_WRFULL;
                default: offer = 2'b00;
            endcase
        end
        C0_WRFULL = !offer[0];
        C1_WRFULL = !offer[1];
    end

    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            turn_q   <= 1'b0;
            grant_q  <= 1'b0;
            rem_q    <= 4'd0;
            offer_q  <= 2'b00;
            ERR      <= 1'b0;
            DROP_CNT <= '0;
        end else begin
            turn_q  <= turn_d;
            grant_q <= grant_d;
            rem_q   <= rem_d;
            offer_q <= offer;
            if (|drop) begin
                ERR <= 1'b1;
                if (drop_sum[DROP_W]) DROP_CNT <= '1;
                else                  DROP_CNT <= drop_sum[DROP_W-1:0];
            end
        end
    end

    assign rd0 = C0_RDEN && hb_valid && !hb_dst;
    assign rd1 = C1_RDEN && hb_valid && hb_dst;

    always_ff @(posedge CLK) begin
        if (!RESETn) rx_q <= HDR;
        else         rx_q <= rx_d;
    end

    always_comb begin
        rx_d = rx_q;
        unique case (rx_q)
            HDR: if (pop_q && pkt_len(H_RDDATA[6:4]) != 4'd0) rx_d = PAY;
            PAY: if (pop_q && rrem_q == 4'd1) rx_d = HDR;
            default: rx_d = HDR;
        endcase
    end

    always_comb begin
        H_RDEN     = RESETn && !H_RDEMPTY && !pop_q && !hb_valid;
        C0_RDEMPTY = !(hb_valid && !hb_dst);
        C1_RDEMPTY = !(hb_valid && hb_dst);
    end

    // pop_q and hb_valid are exclusive, so a load never races a client read
    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            pop_q     <= 1'b0;
            hb        <= 8'd0;
            hb_valid  <= 1'b0;
            hb_dst    <= 1'b0;
            dst_q     <= 1'b0;
            rrem_q    <= 4'd0;
            C0_RDDATA <= 8'd0;
            C1_RDDATA <= 8'd0;
        end else begin
            pop_q <= H_RDEN;
            if (pop_q && rx_q == HDR) begin
                dst_q  <= H_RDDATA[7];
                rrem_q <= pkt_len(H_RDDATA[6:4]);
            end
            if (pop_q && rx_q == PAY) begin
                hb       <= H_RDDATA;
                hb_valid <= 1'b1;
                hb_dst   <= dst_q;
                rrem_q   <= rrem_q - 4'd1;
            end else if (rd0 || rd1) begin
                hb_valid <= 1'b0;
            end
            if (rd0) C0_RDDATA <= hb;
            if (rd1) C1_RDDATA <= hb;
        end
    end

endmodule

// File: tb/tb_host_fifo_arb.sv
// Directed bench for host_fifo_arb: behavioural clients and host FIFOs
// drive the DUT; captured byte streams are compared with hand-built lists.
module tb_host_fifo_arb;

    logic       CLK = 1'b0;
    logic       RESETn = 1'b0;
    logic       C0_WREN = 1'b0, C1_WREN = 1'b0;
    logic [7:0] C0_WRDATA = 8'd0, C1_WRDATA = 8'd0;
    logic       C0_WRFULL, C1_WRFULL;
    logic       C0_RDEN = 1'b0, C1_RDEN = 1'b0;
    logic       C0_RDEMPTY, C1_RDEMPTY;
    logic [7:0] C0_RDDATA, C1_RDDATA;
    logic       H_WREN;
    logic [7:0] H_WRDATA;
    logic       H_WRFULL = 1'b0;
    logic       H_RDEN;
    logic       H_RDEMPTY = 1'b1;
    logic [7:0] H_RDDATA = 8'd0;
    logic       ERR;
    logic [7:0] DROP_CNT;

    host_fifo_arb #(.DROP_W(8)) dut (
        .CLK(CLK), .RESETn(RESETn),
        .C0_WREN(C0_WREN), .C0_WRDATA(C0_WRDATA), .C0_WRFULL(C0_WRFULL),
        .C0_RDEN(C0_RDEN), .C0_RDEMPTY(C0_RDEMPTY), .C0_RDDATA(C0_RDDATA),
        .C1_WREN(C1_WREN), .C1_WRDATA(C1_WRDATA), .C1_WRFULL(C1_WRFULL),
        .C1_RDEN(C1_RDEN), .C1_RDEMPTY(C1_RDEMPTY), .C1_RDDATA(C1_RDDATA),
        .H_WREN(H_WREN), .H_WRDATA(H_WRDATA), .H_WRFULL(H_WRFULL),
        .H_RDEN(H_RDEN), .H_RDEMPTY(H_RDEMPTY), .H_RDDATA(H_RDDATA),
        .ERR(ERR), .DROP_CNT(DROP_CNT)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] q0[$], q1[$], hostq[$], hrx[$], got0[$], got1[$], expq[$];
    logic wf0 = 1'b1, wf1 = 1'b1, e0 = 1'b1, e1 = 1'b1;
    logic hren_s = 1'b0, rd0_e = 1'b0, rd1_e = 1'b0;
    logic c1_off = 1'b0, c0_ne = 1'b0;
    int   stray1 = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Mid-cycle monitor: everything has settled since the last edge
    always @(negedge CLK) begin
        wf0 = C0_WRFULL;
        wf1 = C1_WRFULL;
        e0 = C0_RDEMPTY;
        e1 = C1_RDEMPTY;
        hren_s = H_RDEN;
        if (H_WREN) hostq.push_back(H_WRDATA);
        if (!C1_WRFULL) c1_off = 1'b1;
        if (!C0_RDEMPTY) c0_ne = 1'b1;
        if (rd0_e) got0.push_back(C0_RDDATA);
        if (rd1_e) got1.push_back(C1_RDDATA);
    end

    // Registered client and host-FIFO behaviour, driven just after the edge
    always @(posedge CLK) begin
        rd0_e = C0_RDEN;
        rd1_e = C1_RDEN;
        #1;
        if (!wf0 && q0.size() > 0) begin
            C0_WREN = 1'b1;
            C0_WRDATA = q0.pop_front();
        end else C0_WREN = 1'b0;
        if (stray1 > 0) begin
            C1_WREN = 1'b1;
            C1_WRDATA = 8'h55;
            stray1--;
        end else if (!wf1 && q1.size() > 0) begin
            C1_WREN = 1'b1;
            C1_WRDATA = q1.pop_front();
        end else C1_WREN = 1'b0;
        C0_RDEN = !e0 && !C0_RDEN;
        C1_RDEN = !e1 && !C1_RDEN;
        if (hren_s && hrx.size() > 0) H_RDDATA = hrx.pop_front();
        H_RDEMPTY = (hrx.size() == 0);
    end

    task automatic settle();
        @(negedge CLK);
        #1;
    endtask

    task automatic clear_caps();
        hostq.delete();
        got0.delete();
        got1.delete();
        c1_off = 1'b0;
        c0_ne = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge CLK);
        #2 RESETn = 1'b0;
        q0.delete();
        q1.delete();
        repeat (3) @(posedge CLK);
        #2 RESETn = 1'b1;
        clear_caps();
    endtask

    task automatic chk_reset(input string t);
        check({t, " c0_wrfull"}, C0_WRFULL, 1);
        check({t, " c1_wrfull"}, C1_WRFULL, 1);
        check({t, " c0_rdempty"}, C0_RDEMPTY, 1);
        check({t, " c1_rdempty"}, C1_RDEMPTY, 1);
        check({t, " c0_rddata"}, C0_RDDATA, 0);
        check({t, " c1_rddata"}, C1_RDDATA, 0);
        check({t, " h_wren"}, H_WREN, 0);
        check({t, " h_rden"}, H_RDEN, 0);
        check({t, " err"}, ERR, 0);
        check({t, " drop_cnt"}, DROP_CNT, 0);
    endtask

    task automatic wait_host(input string t, input int n);
        int k = 0;
        while (hostq.size() < n && k < 400) begin
            settle();
            k++;
        end
        check({t, " host count"}, hostq.size(), n);
    endtask

    task automatic wait_rx(input string t, input int n0, input int n1);
        int k = 0;
        while ((got0.size() < n0 || got1.size() < n1) && k < 200) begin
            settle();
            k++;
        end
        check({t, " c0 count"}, got0.size(), n0);
        check({t, " c1 count"}, got1.size(), n1);
    endtask

    task automatic cmp_host(input string t);
        for (int i = 0; i < expq.size(); i++)
            check($sformatf("%s byte%0d", t, i),
                  (i < hostq.size()) ? {24'd0, hostq[i]} : 32'hDEAD,
                  {24'd0, expq[i]});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset values, with a host RX byte pending to exercise H_RDEN gating
        hrx.push_back(8'h00);
        repeat (2) @(posedge CLK);
        settle();
        chk_reset("rst");
        #2 RESETn = 1'b1;
        clear_caps();

        // 1: single C0 packet, C1 idle
        do_reset();
        q0 = '{8'h40, 8'hA1, 8'hB2, 8'hC3, 8'hD4};
        wait_host("t1", 5);
        check("t1 c1 offered", c1_off, 0);
        expq = '{8'h40, 8'hA1, 8'hB2, 8'hC3, 8'hD4};
        cmp_host("t1");
        check("t1 err", ERR, 0);

        // 2: both stream two 9-byte packets, no interleave
        do_reset();
        q0 = '{8'h70, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08,
               8'h70, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h18};
        q1 = '{8'hF0, 8'h81, 8'h82, 8'h83, 8'h84, 8'h85, 8'h86, 8'h87, 8'h88,
               8'hF0, 8'h91, 8'h92, 8'h93, 8'h94, 8'h95, 8'h96, 8'h97, 8'h98};
        wait_host("t2", 36);
        expq = '{8'h70, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08,
                 8'hF0, 8'h81, 8'h82, 8'h83, 8'h84, 8'h85, 8'h86, 8'h87, 8'h88,
                 8'h70, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h18,
                 8'hF0, 8'h91, 8'h92, 8'h93, 8'h94, 8'h95, 8'h96, 8'h97, 8'h98};
        cmp_host("t2");

        // 3: host TX full for 3 cycles mid-packet
        do_reset();
        q0 = '{8'h40, 8'h21, 8'h22, 8'h23, 8'h24};
        wait_host("t3 pre", 2);
        @(posedge CLK);
        #2 H_WRFULL = 1'b1;
        for (int i = 0; i < 3; i++) begin
            settle();
            check($sformatf("t3 c0_wrfull%0d", i), C0_WRFULL, 1);
            if (i > 0) check($sformatf("t3 h_wren%0d", i), H_WREN, 0);
        end
        @(posedge CLK);
        #2 H_WRFULL = 1'b0;
        wait_host("t3", 5);
        expq = '{8'h40, 8'h21, 8'h22, 8'h23, 8'h24};
        cmp_host("t3");

        // 4: host RX routing and header stripping
        do_reset();
        hrx.push_back(8'hA0);
        hrx.push_back(8'h12);
        hrx.push_back(8'h34);
        wait_rx("t4a", 0, 2);
        check("t4 c1 b0", (got1.size() > 0) ? {24'd0, got1[0]} : 32'hDEAD, 32'h12);
        check("t4 c1 b1", (got1.size() > 1) ? {24'd0, got1[1]} : 32'hDEAD, 32'h34);
        check("t4 c0 nonempty", c0_ne, 0);
        hrx.push_back(8'h80);
        hrx.push_back(8'h10);
        hrx.push_back(8'h99);
        wait_rx("t4b", 1, 2);
        check("t4 c0 b0", (got0.size() > 0) ? {24'd0, got0[0]} : 32'hDEAD, 32'h99);

        // 5: stray C1 writes while nothing is offered; counter saturates
        H_WRFULL = 1'b1;
        do_reset();
        stray1 = 1;
        repeat (4) @(posedge CLK);
        settle();
        check("t5 h_wren count", hostq.size(), 0);
        check("t5 err", ERR, 1);
        check("t5 drop_cnt", DROP_CNT, 1);
        stray1 = 260;
        repeat (265) @(posedge CLK);
        settle();
        check("t5 drop sat", DROP_CNT, 8'hFF);
        check("t5 err held", ERR, 1);

        // 6: reset mid-packet clears everything; next byte is a header
        @(posedge CLK);
        #2 H_WRFULL = 1'b0;
        clear_caps();
        q0 = '{8'h30, 8'h01, 8'h02, 8'h03};
        wait_host("t6 pre", 2);
        @(posedge CLK);
        #2 RESETn = 1'b0;
        q0.delete();
        hrx.push_back(8'h00);
        repeat (2) @(posedge CLK);
        settle();
        chk_reset("t6 rst");
        @(posedge CLK);
        #2 RESETn = 1'b1;
        clear_caps();
        q0 = '{8'h10, 8'h77};
        q1 = '{8'h00};
        wait_host("t6", 3);
        expq = '{8'h10, 8'h77, 8'h00};
        cmp_host("t6");
        check("t6 err", ERR, 0);
        check("t6 drop_cnt", DROP_CNT, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
